// File: rtl/ofmap_wb_pkg.sv
// Shared definitions for the ofmap writeback buffer.
//   wb_state_e  : layer-level state of the buffer (IDLE/COLLECT/DRAIN/DONE)
//   ERR_*       : bit positions inside the sticky error vector
//   count_width : width of the occupancy counter for a given RAM address width
package ofmap_wb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    DRAIN   = 2'd2,
    DONE    = 2'd3
  } wb_state_e;

  localparam int ERR_OVF  = 0;
  localparam int ERR_UDF  = 1;
  localparam int ERR_ADDR = 2;
  localparam int ERR_W    = 3;

  // One extra bit so that a completely full buffer is representable.
  function automatic int count_width(input int addr_bit);
    return addr_bit + 1;
  endfunction

endpackage

// File: rtl/sync_fifo_fwft.sv
// Synchronous first-word-fall-through FIFO.
// Ports:
//   clk, rst     : clock and synchronous active-high reset
//   flush        : synchronous clear of pointers and occupancy
//   push, push_data : write request and row; ignored when full
//   pop          : consume head entry; ignored when empty
//   head_data    : current head entry, combinational from the read pointer
//   count        : registered occupancy
//   full, empty  : decoded from count
module sync_fifo_fwft #(
  parameter int WIDTH = 512,
  parameter int DEPTH = 1024,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count_q;
  logic             do_push;
  logic             do_pop;

  // Full/empty come from the occupancy counter, so pointer equality is never
  // ambiguous and the pointers may simply wrap modulo DEPTH.
  assign full      = (count_q == CNT_W'(DEPTH));
  assign empty     = (count_q == '0);
  assign do_push   = push && !full;
  assign do_pop    = pop && !empty;
  assign count     = count_q;
  assign head_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/ofmap_writeback_buffer.sv
// Ofmap writeback buffer: collects MAC-array output rows during computation
// and hands them to the ofmap RAM, row per controller write strobe, with the
// data valid in the same cycle as the strobe.
// Ports:
//   clk, rst              : clock, synchronous active-high reset
//   start_in              : layer start / abort; flushes buffer and errors
//   psum_valid_in/psum_data_in : MAC output row push
//   mac_done_in           : computation finished, begin draining
//   ofmap_ready_out       : buffer has a row available while draining
//   ofmap_write_en_in/ofmap_addr_in : controller write strobe and address
//   ofmap_data_out        : head row for the RAM wdata port (0 when empty)
//   ofmap_write_done_in   : controller finished the layer early
//   done_out              : one-cycle pulse when the layer has drained
//   busy_out              : high while collecting or draining
//   count_out             : buffer occupancy
//   err_out               : sticky errors [0] overflow [1] underflow [2] addr
module ofmap_writeback_buffer
  import ofmap_wb_pkg::*;
#(
  parameter int MAC_COL        = 16,
  parameter int OFMAP_BITWIDTH = 32,
  parameter int OFMAP_ADDR_BIT = 10,
  parameter int OFMAP_DATA_NUM = 784,
  parameter int FIFO_DEPTH     = 1024
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                start_in,
  input  logic                                psum_valid_in,
  input  logic [OFMAP_BITWIDTH*MAC_COL-1:0]   psum_data_in,
  input  logic                                mac_done_in,
  output logic                                ofmap_ready_out,
  input  logic                                ofmap_write_en_in,
  input  logic [OFMAP_ADDR_BIT-1:0]           ofmap_addr_in,
  output logic [OFMAP_BITWIDTH*MAC_COL-1:0]   ofmap_data_out,
  input  logic                                ofmap_write_done_in,
  output logic                                done_out,
  output logic                                busy_out,
  output logic [OFMAP_ADDR_BIT:0]             count_out,
  output logic [2:0]                          err_out
);

  localparam int ROW_W      = OFMAP_BITWIDTH * MAC_COL;
  localparam int CNT_W      = count_width(OFMAP_ADDR_BIT);
  localparam int FIFO_CNT_W = $clog2(FIFO_DEPTH) + 1;

  wb_state_e              state;
  wb_state_e              next_state;
  logic [CNT_W-1:0]       drain_cnt;
  logic [ERR_W-1:0]       err;
  logic                   busy_q;
  logic                   done_q;
  logic                   busy_d;
  logic                   done_d;

  logic                   fifo_flush;
  logic                   fifo_push;
  logic                   fifo_pop;
  logic [ROW_W-1:0]       fifo_head;
  logic [FIFO_CNT_W-1:0]  fifo_count;
  logic                   fifo_full;
  logic                   fifo_empty;

  logic                   in_collect;
  logic                   in_drain;
  logic                   last_pop;
  logic                   addr_bad;

  // start_in overrides everything else in its cycle, so the per-state events
  // are only live when no start is present.
  assign in_collect = (state == COLLECT) && !start_in;
  assign in_drain   = (state == DRAIN) && !start_in;
  assign fifo_push  = in_collect && psum_valid_in;
  assign fifo_pop   = in_drain && ofmap_write_en_in && !fifo_empty;
  // Leaving DONE discards whatever the controller did not write.
  assign fifo_flush = start_in || (state == DONE);
  assign last_pop   = fifo_pop && (drain_cnt == CNT_W'(OFMAP_DATA_NUM - 1));
  assign addr_bad   = (ofmap_addr_in != drain_cnt[OFMAP_ADDR_BIT-1:0]);

  sync_fifo_fwft #(
    .WIDTH (ROW_W),
    .DEPTH (FIFO_DEPTH),
    .CNT_W (FIFO_CNT_W)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (fifo_flush),
    .push      (fifo_push),
    .push_data (psum_data_in),
    .pop       (fifo_pop),
    .head_data (fifo_head),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    if (start_in) begin
      next_state = COLLECT;
    end else begin
      case (state)
        IDLE:    next_state = IDLE;
        COLLECT: if (mac_done_in) next_state = DRAIN;
        DRAIN:   if (last_pop || ofmap_write_done_in) next_state = DONE;
        DONE:    next_state = IDLE;
        default: next_state = IDLE;
      endcase
    end
  end

  // busy/done are decoded from next_state and registered, so they line up
  // exactly with the state they describe.
  always_comb begin
    busy_d          = (next_state == COLLECT) || (next_state == DRAIN);
    done_d          = (next_state == DONE);
    ofmap_ready_out = (state == DRAIN) && !fifo_empty;
    ofmap_data_out  = ofmap_ready_out ? fifo_head : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || start_in) begin
      drain_cnt <= '0;
    end else if (fifo_pop) begin
      drain_cnt <= drain_cnt + CNT_W'(1);
    end
  end

  // The address check runs on every strobe in DRAIN; a mismatch does not
  // block the pop, it only flags the error.
  always_ff @(posedge clk) begin
    if (rst || start_in) begin
      err <= '0;
    end else begin
      if (in_collect && psum_valid_in && fifo_full) err[ERR_OVF] <= 1'b1;
      if (in_collect && ofmap_write_en_in)          err[ERR_UDF] <= 1'b1;
      if (in_drain && psum_valid_in)                err[ERR_OVF] <= 1'b1;
      if (in_drain && ofmap_write_en_in && fifo_empty) err[ERR_UDF] <= 1'b1;
      if (in_drain && ofmap_write_en_in && addr_bad)   err[ERR_ADDR] <= 1'b1;
    end
  end

  assign busy_out  = busy_q;
  assign done_out  = done_q;
  assign err_out   = err;
  assign count_out = CNT_W'(fifo_count);

endmodule

// File: tb/tb_ofmap_writeback_buffer.sv
// Self-checking bench for ofmap_writeback_buffer. A queue-based model of the
// layer buffer predicts every output each cycle; directed layers cover the
// nominal, overflow, address-skip, early-done, empty-drain, abort and reset
// cases, then randomized layers exercise mixed traffic.
module tb_ofmap_writeback_buffer;

  localparam int ROW_W    = 512;
  localparam int DEPTH    = 1024;
  localparam int DATA_NUM = 784;

  localparam int P_IDLE    = 0;
  localparam int P_COLLECT = 1;
  localparam int P_DRAIN   = 2;
  localparam int P_DONE    = 3;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start_in = 1'b0;
  logic             psum_valid_in = 1'b0;
  logic [ROW_W-1:0] psum_data_in = '0;
  logic             mac_done_in = 1'b0;
  logic             ofmap_ready_out;
  logic             ofmap_write_en_in = 1'b0;
  logic [9:0]       ofmap_addr_in = '0;
  logic [ROW_W-1:0] ofmap_data_out;
  logic             ofmap_write_done_in = 1'b0;
  logic             done_out;
  logic             busy_out;
  logic [10:0]      count_out;
  logic [2:0]       err_out;

  int checks = 0;
  int errors = 0;

  logic [ROW_W-1:0] q[$];
  int               m_phase = P_IDLE;
  int               m_dcnt  = 0;
  logic [2:0]       m_err   = '0;

  ofmap_writeback_buffer dut (
    .clk                 (clk),
    .rst                 (rst),
    .start_in            (start_in),
    .psum_valid_in       (psum_valid_in),
    .psum_data_in        (psum_data_in),
    .mac_done_in         (mac_done_in),
    .ofmap_ready_out     (ofmap_ready_out),
    .ofmap_write_en_in   (ofmap_write_en_in),
    .ofmap_addr_in       (ofmap_addr_in),
    .ofmap_data_out      (ofmap_data_out),
    .ofmap_write_done_in (ofmap_write_done_in),
    .done_out            (done_out),
    .busy_out            (busy_out),
    .count_out           (count_out),
    .err_out             (err_out)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [ROW_W-1:0] obs,
                             input logic [ROW_W-1:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s at %0t: got %h expected %h", tag, $time, obs, exp);
    end
  endtask

  task automatic checkState();
    logic             e_ready;
    logic [ROW_W-1:0] e_data;
    e_ready = (m_phase == P_DRAIN) && (q.size() != 0);
    e_data  = e_ready ? q[0] : '0;
    checkOutput("count", ROW_W'(count_out), ROW_W'(q.size()));
    checkOutput("err",   ROW_W'(err_out),   ROW_W'(m_err));
    checkOutput("busy",  ROW_W'(busy_out),
                ROW_W'((m_phase == P_COLLECT) || (m_phase == P_DRAIN)));
    checkOutput("done",  ROW_W'(done_out),  ROW_W'(m_phase == P_DONE));
    checkOutput("ready", ROW_W'(ofmap_ready_out), ROW_W'(e_ready));
    checkOutput("data",  ofmap_data_out, e_data);
  endtask

  function automatic logic [ROW_W-1:0] rand_row();
    logic [ROW_W-1:0] r;
    for (int k = 0; k < 16; k++) r[k*32 +: 32] = $urandom;
    return r;
  endfunction

  function automatic logic [ROW_W-1:0] index_row(input int i);
    logic [ROW_W-1:0] r;
    for (int k = 0; k < 16; k++) r[k*32 +: 32] = 32'(i);
    return r;
  endfunction

  // One clock cycle: check what the DUT shows now, drive this cycle's inputs,
  // advance the model by the layer rules, then step past the next edge.
  task automatic applyStimulus(input logic st, input logic pv,
                               input logic [ROW_W-1:0] pd, input logic md,
                               input logic we, input logic [9:0] addr,
                               input logic wd);
    bit popped;
    checkState();
    start_in            = st;
    psum_valid_in       = pv;
    psum_data_in        = pd;
    mac_done_in         = md;
    ofmap_write_en_in   = we;
    ofmap_addr_in       = addr;
    ofmap_write_done_in = wd;
    popped = 0;
    if (st) begin
      q.delete();
      m_err   = '0;
      m_dcnt  = 0;
      m_phase = P_COLLECT;
    end else begin
      case (m_phase)
        P_COLLECT: begin
          if (pv) begin
            if (q.size() < DEPTH) q.push_back(pd);
            else m_err[0] = 1'b1;
          end
          if (we) m_err[1] = 1'b1;
          if (md) m_phase = P_DRAIN;
        end
        P_DRAIN: begin
          if (pv) m_err[0] = 1'b1;
          if (we) begin
            if (int'(addr) != (m_dcnt % DEPTH)) m_err[2] = 1'b1;
            if (q.size() == 0) m_err[1] = 1'b1;
            else begin
              void'(q.pop_front());
              m_dcnt++;
              popped = 1;
            end
          end
          if ((popped && m_dcnt == DATA_NUM) || wd) m_phase = P_DONE;
        end
        P_DONE: begin
          q.delete();
          m_phase = P_IDLE;
        end
        default: ;
      endcase
    end
    @(posedge clk);
    #1;
  endtask

  task automatic applyReset();
    rst = 1'b1;
    start_in = 0; psum_valid_in = 0; psum_data_in = '0; mac_done_in = 0;
    ofmap_write_en_in = 0; ofmap_addr_in = '0; ofmap_write_done_in = 0;
    q.delete();
    m_err = '0; m_dcnt = 0; m_phase = P_IDLE;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(0, 0, '0, 0, 0, '0, 0);
  endtask

  task automatic push_rows(input int n, input bit indexed);
    for (int i = 0; i < n; i++)
      applyStimulus(0, 1, indexed ? index_row(i) : rand_row(), 0, 0, '0, 0);
  endtask

  task automatic write_rows(input int first, input int n);
    for (int i = first; i < first + n; i++)
      applyStimulus(0, 0, '0, 0, 1, 10'(i), 0);
  endtask

  initial begin
    int n;
    logic we;
    logic [9:0] addr;

    applyReset();
    idle(2);

    // Nominal layer with row i = i in every element.
    applyStimulus(1, 0, '0, 0, 0, '0, 0);
    push_rows(DATA_NUM, 1);
    applyStimulus(0, 0, '0, 1, 0, '0, 0);
    write_rows(0, DATA_NUM);
    idle(3);

    // Overflow: the 1025th row is dropped and never appears on the output.
    applyStimulus(1, 0, '0, 0, 0, '0, 0);
    push_rows(DEPTH + 1, 1);
    applyStimulus(0, 0, '0, 1, 0, '0, 0);
    write_rows(0, DATA_NUM);
    idle(3);

    // Address skip: writes 0..4 then 6; the sixth row still comes out.
    applyStimulus(1, 0, '0, 0, 0, '0, 0);
    push_rows(10, 0);
    applyStimulus(0, 0, '0, 1, 0, '0, 0);
    write_rows(0, 5);
    applyStimulus(0, 0, '0, 0, 1, 10'd6, 0);
    applyStimulus(0, 0, '0, 0, 0, '0, 1);
    idle(3);

    // Early write_done; last push shares the cycle with mac_done.
    applyStimulus(1, 0, '0, 0, 0, '0, 0);
    push_rows(9, 0);
    applyStimulus(0, 1, rand_row(), 1, 0, '0, 0);
    write_rows(0, 3);
    applyStimulus(0, 0, '0, 0, 0, '0, 1);
    idle(2);
    applyStimulus(1, 0, '0, 0, 0, '0, 0);
    idle(1);

    // Empty buffer in DRAIN: ready and data must both read 0.
    applyStimulus(1, 0, '0, 0, 0, '0, 0);
    push_rows(2, 0);
    applyStimulus(0, 0, '0, 1, 0, '0, 0);
    write_rows(0, 2);
    idle(3);
    applyStimulus(0, 0, '0, 0, 0, '0, 1);
    idle(2);

    // Abort mid-DRAIN with 100 rows left and an underflow already flagged.
    applyStimulus(1, 0, '0, 0, 0, '0, 0);
    applyStimulus(0, 0, '0, 0, 1, '0, 0);
    push_rows(200, 0);
    applyStimulus(0, 0, '0, 1, 0, '0, 0);
    write_rows(0, 100);
    applyStimulus(1, 0, '0, 0, 0, '0, 0);
    idle(2);

    // Reset in the middle of COLLECT.
    applyStimulus(1, 0, '0, 0, 0, '0, 0);
    push_rows(5, 0);
    applyReset();
    idle(2);

    // Randomized layers.
    for (int ep = 0; ep < 20; ep++) begin
      applyStimulus(1, 0, '0, 0, 0, '0, 0);
      n = $urandom_range(1, 60);
      for (int c = 0; c < n; c++)
        applyStimulus(0, $urandom_range(0, 3) != 0, rand_row(), 0,
                      $urandom_range(0, 19) == 0, '0, 0);
      applyStimulus(0, 1'($urandom_range(0, 1)), rand_row(), 1, 0, '0, 0);
      for (int c = 0; c < 200 && m_phase == P_DRAIN; c++) begin
        we   = $urandom_range(0, 3) != 0;
        addr = ($urandom_range(0, 9) == 0) ? 10'($urandom) : 10'(m_dcnt);
        applyStimulus($urandom_range(0, 199) == 0, $urandom_range(0, 29) == 0,
                      rand_row(), 0, we, addr, $urandom_range(0, 49) == 0);
      end
      idle(2);
    end

    checkState();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
